wb_queue_stage: RTL and testbench

Parametrised writeback stage with a DEPTH-entry result queue between MEM and the register-file write port. It accepts MEM results with a valid/ack handshake and decodes whether each instruction writes a register. Writing results are queued in order and retired to the register file only when the write port is granted. Each retirement pulses an unlock to ID, and a forwarding lookup gives ID/EX the youngest queued value for a source register.

---
 rtl/wb_queue_stage.sv | 112 +++++++++++
 tb/tb_wb_queue_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue_stage.sv
// wb_queue_stage: writeback result queue between MEM and the register-file
// write port. Register-writing results are queued in order, retired on a
// write grant (with an unlock pulse to ID), and searched for forwarding.
module wb_queue_stage #(
   parameter int BITSIZE = 32,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst_i,
   input  logic               valid_i,
   input  logic [31:0]        instr_i,
   input  logic [BITSIZE-1:0] data_i,
   output logic               ack_o,
   output logic               rf_we_o,
   output logic [4:0]         rf_rd_o,
   output logic [BITSIZE-1:0] rf_data_o,
   input  logic               rf_gnt_i,
   output logic               unlock_o,
   output logic [4:0]         unlock_rd_o,
   input  logic [4:0]         fwd_rs_i,
   output logic               fwd_hit_o,
   output logic [BITSIZE-1:0] fwd_data_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_IMM_ALU = 7'b0010011;
   localparam logic [6:0] OP_REG_ALU = 7'b0110011;
   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;

   // An instruction writes the register file only for these opcodes and rd != x0
   function automatic logic writes_reg(input logic [31:0] instr);
      logic op_wr;
      case (instr[6:0])
         OP_LUI, OP_IMM_ALU, OP_REG_ALU, OP_LOAD,
         OP_JAL, OP_JALR, OP_AUIPC: op_wr = 1'b1;
         default:                   op_wr = 1'b0;
      endcase
      return op_wr && (instr[11:7] != 5'd0);
   endfunction

   logic [4:0]         rd_mem   [DEPTH];
   logic [BITSIZE-1:0] data_mem [DEPTH];
   logic [PW-1:0]      head_q, tail_q;
   logic [CW-1:0]      count_q;

   logic is_writer, retire, enq;

   // Handshake: writers need a free slot or a slot freed by this cycle's retire
   always_comb begin
      is_writer = writes_reg(instr_i);
      rf_we_o   = (count_q != '0);
      retire    = rf_we_o && rf_gnt_i;
      ack_o     = valid_i && (!is_writer || (count_q < FULL) || retire);
      enq       = ack_o && is_writer;
   end

   // Head entry drives the write port; unlock mirrors the retiring entry
   always_comb begin
      rf_rd_o     = rf_we_o ? rd_mem[head_q]   : 5'd0;
      rf_data_o   = rf_we_o ? data_mem[head_q] : '0;
      unlock_o    = retire;
      unlock_rd_o = rf_rd_o;
      count_o     = count_q;
   end

   // Forwarding: scan oldest to youngest so the last match (nearest tail) wins
   always_comb begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < count_q) && (fwd_rs_i != 5'd0) &&
             (rd_mem[head_q + PW'(i)] == fwd_rs_i)) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = data_mem[head_q + PW'(i)];
         end
      end
   end

   // Queue control state: pointers wrap naturally at DEPTH (power of two)
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (enq)    tail_q <= tail_q + 1'b1;
         if (retire) head_q <= head_q + 1'b1;
         case ({enq, retire})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; contents need no reset since validity lives in count/pointers
   always_ff @(posedge clk) begin
      if (enq) begin
         rd_mem[tail_q]   <= instr_i[11:7];
         data_mem[tail_q] <= data_i;
      end
   end

endmodule

// File: tb/tb_wb_queue_stage.sv
// Testbench for wb_queue_stage: scoreboard of queued writes compared against
// the register-file port, forwarding and handshake outputs every cycle.
module tb_wb_queue_stage;

   localparam int BITSIZE = 32;
   localparam int DEPTH   = 4;

   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   logic               clk = 1'b0;
   logic               rst_i;
   logic               valid_i;
   logic [31:0]        instr_i;
   logic [BITSIZE-1:0] data_i;
   logic               ack_o;
   logic               rf_we_o;
   logic [4:0]         rf_rd_o;
   logic [BITSIZE-1:0] rf_data_o;
   logic               rf_gnt_i;
   logic               unlock_o;
   logic [4:0]         unlock_rd_o;
   logic [4:0]         fwd_rs_i;
   logic               fwd_hit_o;
   logic [BITSIZE-1:0] fwd_data_o;
   logic [$clog2(DEPTH):0] count_o;

   wb_queue_stage #(.BITSIZE(BITSIZE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_i(rst_i), .valid_i(valid_i), .instr_i(instr_i),
      .data_i(data_i), .ack_o(ack_o), .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o),
      .rf_data_o(rf_data_o), .rf_gnt_i(rf_gnt_i), .unlock_o(unlock_o),
      .unlock_rd_o(unlock_rd_o), .fwd_rs_i(fwd_rs_i), .fwd_hit_o(fwd_hit_o),
      .fwd_data_o(fwd_data_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]         rd;
      logic [BITSIZE-1:0] data;
   } ent_t;

   ent_t sb[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd);
      return {20'h0, rd, op};
   endfunction

   function automatic logic is_writer(input logic [31:0] ins);
      logic op_wr;
      op_wr = (ins[6:0] == 7'b0110111) || (ins[6:0] == 7'b0010011) ||
              (ins[6:0] == 7'b0110011) || (ins[6:0] == 7'b0000011) ||
              (ins[6:0] == 7'b1101111) || (ins[6:0] == 7'b1100111) ||
              (ins[6:0] == 7'b0010111);
      return op_wr && (ins[11:7] != 5'd0);
   endfunction

   // One cycle: drive at negedge, check combinational outputs, update model for the edge
   task automatic step(input logic v, input logic [31:0] ins, input logic [BITSIZE-1:0] d,
                       input logic g, input logic [4:0] rs, output logic acc);
      logic               wr, ewe, eack, ehit;
      logic [BITSIZE-1:0] edata;
      ent_t               e;
      @(negedge clk);
      valid_i  = v;
      instr_i  = ins;
      data_i   = d;
      rf_gnt_i = g;
      fwd_rs_i = rs;
      #2;
      wr   = is_writer(ins);
      ewe  = (sb.size() != 0);
      eack = v && (!wr || (sb.size() < DEPTH) || (ewe && g));
      check("ack", ack_o, eack);
      check("rf_we", rf_we_o, ewe);
      check("count", count_o, sb.size());
      check("unlock", unlock_o, ewe && g);
      ehit  = 1'b0;
      edata = '0;
      if (rs != 5'd0)
         for (int i = 0; i < sb.size(); i++)
            if (sb[i].rd == rs) begin
               ehit  = 1'b1;
               edata = sb[i].data;
            end
      check("fwd_hit", fwd_hit_o, ehit);
      check("fwd_data", fwd_data_o, edata);
      if (ewe) begin
         check("rf_rd", rf_rd_o, sb[0].rd);
         check("rf_data", rf_data_o, sb[0].data);
         check("unlock_rd", unlock_rd_o, sb[0].rd);
         if (g) void'(sb.pop_front());
      end else begin
         check("rf_rd_empty", rf_rd_o, 5'd0);
         check("rf_data_empty", rf_data_o, '0);
      end
      if (eack && wr) begin
         e.rd   = ins[11:7];
         e.data = d;
         sb.push_back(e);
      end
      acc = eack;
   endtask

   task automatic drain();
      logic a;
      int   n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         step(1'b0, 32'h0, '0, 1'b1, 5'd0, a);
         n++;
      end
      check("drain_done", sb.size(), 0);
      step(1'b0, 32'h0, '0, 1'b1, 5'd0, a);
   endtask

   initial begin
      logic a;
      int   tries;
      rst_i = 1'b1; valid_i = 1'b0; instr_i = '0; data_i = '0;
      rf_gnt_i = 1'b0; fwd_rs_i = 5'd0;
      #2;
      check("rst_count", count_o, 0);
      check("rst_we", rf_we_o, 0);
      check("rst_ack", ack_o, 0);
      check("rst_unlock", unlock_o, 0);
      @(negedge clk);
      rst_i = 1'b0;
      step(1'b0, 32'h0, '0, 1'b1, 5'd0, a);

      // Single writer with grant held high
      step(1'b1, mk(OP_IMM, 5'd5), 32'hDEADBEEF, 1'b1, 5'd0, a);
      step(1'b0, 32'h0, '0, 1'b1, 5'd5, a);
      step(1'b0, 32'h0, '0, 1'b1, 5'd0, a);

      // Non-writers are acked and discarded
      step(1'b1, mk(OP_STORE, 5'd3), 32'h11, 1'b1, 5'd0, a);
      step(1'b1, mk(OP_BR, 5'd4), 32'h22, 1'b1, 5'd0, a);
      step(1'b1, mk(OP_REG, 5'd0), 32'h33, 1'b1, 5'd0, a);
      step(1'b0, 32'h0, '0, 1'b1, 5'd0, a);

      // Fill and stall, then grant frees a slot for the held writer
      for (int i = 1; i <= 4; i++)
         step(1'b1, mk(OP_IMM, 5'(i)), 32'(i), 1'b0, 5'd0, a);
      step(1'b1, mk(OP_IMM, 5'd5), 32'd5, 1'b0, 5'd0, a);
      check("full_stall", a, 1'b0);
      step(1'b1, mk(OP_STORE, 5'd9), 32'd9, 1'b0, 5'd0, a);
      step(1'b1, mk(OP_IMM, 5'd5), 32'd5, 1'b1, 5'd0, a);
      check("full_accept", a, 1'b1);
      drain();

      // Forwarding picks the youngest match
      step(1'b1, mk(OP_IMM, 5'd7), 32'd1, 1'b0, 5'd0, a);
      step(1'b1, mk(OP_LUI, 5'd7), 32'd2, 1'b0, 5'd0, a);
      step(1'b1, mk(OP_REG, 5'd8), 32'd3, 1'b0, 5'd0, a);
      step(1'b0, 32'h0, '0, 1'b0, 5'd7, a);
      check("fwd7_hit", fwd_hit_o, 1'b1);
      check("fwd7_data", fwd_data_o, 32'd2);
      step(1'b0, 32'h0, '0, 1'b0, 5'd0, a);
      step(1'b0, 32'h0, '0, 1'b0, 5'd9, a);
      drain();

      // Reset mid-drain with three entries queued
      for (int i = 1; i <= 4; i++)
         step(1'b1, mk(OP_IMM, 5'(i + 10)), 32'(i + 100), 1'b0, 5'd0, a);
      step(1'b0, 32'h0, '0, 1'b1, 5'd0, a);
      @(negedge clk);
      check("pre_rst_count", count_o, 3);
      rst_i = 1'b1; valid_i = 1'b1; instr_i = mk(OP_IMM, 5'd6);
      rf_gnt_i = 1'b1; fwd_rs_i = 5'd12;
      #1;
      check("mid_rst_count", count_o, 0);
      check("mid_rst_we", rf_we_o, 0);
      check("mid_rst_rd", rf_rd_o, 0);
      check("mid_rst_unlock", unlock_o, 0);
      check("mid_rst_fwd", fwd_hit_o, 0);
      check("mid_rst_ack", ack_o, 1);
      sb.delete();
      valid_i = 1'b0;
      @(negedge clk);
      rst_i = 1'b0;
      step(1'b0, 32'h0, '0, 1'b1, 5'd0, a);

      // Wrap-around with random grants
      for (int k = 0; k < 10; k++) begin
         a = 1'b0;
         tries = 0;
         while (!a && tries < 40) begin
            step(1'b1, mk(OP_IMM, 5'(k + 1)), 32'hA000 + 32'(k),
                 1'($urandom_range(0, 1)), 5'(k), a);
            tries++;
         end
         if (!a) check("wrap_timeout", 0, 1);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
